// File: rtl/wave_pkg.sv
// Shared types and sizing constants for the wave_capture block.
package wave_pkg;

   localparam int unsigned FRAME_LEN_MAX = 16;
   localparam int unsigned BIT_IDX_W     = 4;
   localparam int unsigned EDGE_CNT_W    = 5;

   typedef enum logic {
      IDLE    = 1'b0,
      CAPTURE = 1'b1
   } state_t;

endpackage : wave_pkg

// File: rtl/wave_edge_det.sv
// Counts 0->1 transitions of the serial stream within the frame being captured.
// Only built when WAVE_CAPTURE_EDGECNT_EN is defined.
module wave_edge_det
   import wave_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  din,
   input  logic                  sample,
   input  logic                  first,
   output logic [EDGE_CNT_W-1:0] count_c
);

   logic                  prev_q;
   logic [EDGE_CNT_W-1:0] acc_q;
   logic                  rise_c;

   // Running count including the bit sampled this cycle; bit 0 restarts the count.
   always_comb begin
      rise_c  = din & ~prev_q;
      count_c = (first ? EDGE_CNT_W'(0) : acc_q) + EDGE_CNT_W'(rise_c);
   end

   // din history is tracked every cycle so bit 0 compares against the previous cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 1'b0;
         acc_q  <= '0;
      end else begin
         prev_q <= din;
         if (sample) acc_q <= count_c;
      end
   end

endmodule : wave_edge_det

// File: rtl/wave_capture.sv
// Serial waveform capture into parallel frames with a one-deep holding register.
// Optional edge counting is enabled by defining WAVE_CAPTURE_EDGECNT_EN.
module wave_capture
   import wave_pkg::*;
#(
   parameter int unsigned FRAME_LEN = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  din,
   input  logic                  en,
   output logic [FRAME_LEN-1:0]  frame_data,
   output logic                  frame_valid,
   input  logic                  frame_ready,
   output logic                  overflow,
   output logic [BIT_IDX_W-1:0]  bit_idx
`ifdef WAVE_CAPTURE_EDGECNT_EN
   ,
   output logic [EDGE_CNT_W-1:0] edge_cnt
`endif
);

   state_t               state;
   logic [FRAME_LEN-1:0] shift_q;
   logic [FRAME_LEN-1:0] shift_next_c;
   logic                 last_c;
   logic                 load_c;

   // Shift direction decides where the first sampled bit ends up.
   generate
      if (MSB_FIRST) begin : g_msb
         assign shift_next_c = {shift_q[FRAME_LEN-2:0], din};
      end else begin : g_lsb
         assign shift_next_c = {din, shift_q[FRAME_LEN-1:1]};
      end
   endgenerate

   // Frame completion and whether the holding register can take it this edge.
   always_comb begin
      last_c = en && (state == CAPTURE) && (bit_idx == BIT_IDX_W'(FRAME_LEN - 1));
      load_c = last_c && (!frame_valid || frame_ready);
   end

   // Capture FSM, shift register and holding register with handshake/overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         bit_idx     <= '0;
         shift_q     <= '0;
         frame_data  <= '0;
         frame_valid <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  state   <= CAPTURE;
                  shift_q <= shift_next_c;
                  bit_idx <= BIT_IDX_W'(1);
               end
            end
            CAPTURE: begin
               if (!en) begin
                  state   <= IDLE;
                  bit_idx <= '0;
                  shift_q <= '0;
               end else begin
                  shift_q <= shift_next_c;
                  bit_idx <= last_c ? BIT_IDX_W'(0) : bit_idx + BIT_IDX_W'(1);
               end
            end
            default: begin
               state   <= IDLE;
               bit_idx <= '0;
            end
         endcase

         if (load_c) begin
            frame_data  <= shift_next_c;
            frame_valid <= 1'b1;
         end else if (last_c) begin
            overflow    <= 1'b1;
         end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
         end
      end
   end

`ifdef WAVE_CAPTURE_EDGECNT_EN
   logic [EDGE_CNT_W-1:0] cnt_c;

   wave_edge_det u_edge_det (
      .clk     (clk),
      .rst     (rst),
      .din     (din),
      .sample  (en),
      .first   (bit_idx == '0),
      .count_c (cnt_c)
   );

   // Edge count travels with frame_data through the holding register.
   always_ff @(posedge clk) begin
      if (rst)         edge_cnt <= '0;
      else if (load_c) edge_cnt <= cnt_c;
   end
`endif

endmodule : wave_capture

// File: tb/tb_wave_capture.sv
// Directed self-checking bench for wave_capture (MSB-first and LSB-first instances).
module tb_wave_capture;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       din = 1'b0;
   logic       en  = 1'b0;
   logic       frame_ready = 1'b0;

   logic [7:0] data_m, data_l;
   logic       valid_m, valid_l;
   logic       ovf_m, ovf_l;
   logic [3:0] idx_m, idx_l;
`ifdef WAVE_CAPTURE_EDGECNT_EN
   logic [4:0] ecnt_m, ecnt_l;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wave_capture #(.FRAME_LEN(8), .MSB_FIRST(1'b1)) u_msb (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .en          (en),
      .frame_data  (data_m),
      .frame_valid (valid_m),
      .frame_ready (frame_ready),
      .overflow    (ovf_m),
      .bit_idx     (idx_m)
`ifdef WAVE_CAPTURE_EDGECNT_EN
      ,
      .edge_cnt    (ecnt_m)
`endif
   );

   wave_capture #(.FRAME_LEN(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .en          (en),
      .frame_data  (data_l),
      .frame_valid (valid_l),
      .frame_ready (frame_ready),
      .overflow    (ovf_l),
      .bit_idx     (idx_l)
`ifdef WAVE_CAPTURE_EDGECNT_EN
      ,
      .edge_cnt    (ecnt_l)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; din = 1'b0; frame_ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // Drives one 8-bit frame, first bit = v[7], leaving en high.
   task automatic send_frame(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) begin
         din = v[i]; en = 1'b1;
         tick();
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_m); end
      checks++; if (data_m !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_m); end
      checks++; if (ovf_m !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf_m); end
      checks++; if (idx_m !== 4'd0 || idx_l !== 4'd0) begin errors++; $display("FAIL reset_idx got %0d/%0d want 0", idx_m, idx_l); end
      checks++; if (ovf_l !== 1'b0 || valid_l !== 1'b0) begin errors++; $display("FAIL reset_lsb got ovf %b valid %b want 0 0", ovf_l, valid_l); end
   endtask

   task automatic test_basic();
      logic [7:0] v;
      do_reset();
      v = 8'hB2;
      for (int i = 7; i >= 0; i--) begin
         din = v[i]; en = 1'b1;
         tick();
         if (i == 1) begin
            checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", valid_m); end
            checks++; if (idx_m !== 4'd7) begin errors++; $display("FAIL basic_idx7 got %0d want 7", idx_m); end
         end
      end
      checks++; if (valid_m !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", valid_m); end
      checks++; if (data_m !== 8'hB2) begin errors++; $display("FAIL basic_msb_data got %h want b2", data_m); end
      checks++; if (valid_l !== 1'b1 || data_l !== 8'h4D) begin errors++; $display("FAIL basic_lsb_data got %h valid %b want 4d 1", data_l, valid_l); end
      checks++; if (idx_m !== 4'd0) begin errors++; $display("FAIL basic_idx_wrap got %0d want 0", idx_m); end
      en = 1'b0; frame_ready = 1'b1;
      tick();
      checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL basic_consume got %b want 0", valid_m); end
      frame_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] frames [3];
      int cyc;
      int hs;
      int hcyc [3];
      frames[0] = 8'hA5; frames[1] = 8'h3C; frames[2] = 8'hF0;
      do_reset();
      frame_ready = 1'b1;
      cyc = 0; hs = 0;
      for (int f = 0; f < 3; f++) begin
         for (int i = 7; i >= 0; i--) begin
            din = frames[f][i]; en = 1'b1;
            tick();
            cyc++;
            if (valid_m === 1'b1) begin
               if (hs < 3) begin
                  checks++; if (data_m !== frames[hs]) begin errors++; $display("FAIL b2b_data%0d got %h want %h", hs, data_m, frames[hs]); end
                  hcyc[hs] = cyc;
               end
               hs++;
            end
         end
      end
      en = 1'b0;
      tick();
      checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", valid_m); end
      checks++; if (hs !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", hs); end
      else begin
         checks++; if (hcyc[1] - hcyc[0] !== 8 || hcyc[2] - hcyc[1] !== 8) begin
            errors++; $display("FAIL b2b_spacing got %0d,%0d want 8,8", hcyc[1] - hcyc[0], hcyc[2] - hcyc[1]);
         end
      end
      checks++; if (ovf_m !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b want 0", ovf_m); end
      frame_ready = 1'b0;
   endtask

   task automatic test_simultaneous();
      logic [7:0] b;
      do_reset();
      send_frame(8'h96);
      checks++; if (valid_m !== 1'b1 || data_m !== 8'h96) begin errors++; $display("FAIL sim_first got %h valid %b want 96 1", data_m, valid_m); end
      b = 8'h2E;
      for (int i = 7; i >= 0; i--) begin
         din = b[i]; en = 1'b1; frame_ready = (i == 0);
         tick();
      end
      checks++; if (valid_m !== 1'b1 || data_m !== 8'h2E) begin errors++; $display("FAIL sim_load got %h valid %b want 2e 1", data_m, valid_m); end
      checks++; if (ovf_m !== 1'b0) begin errors++; $display("FAIL sim_ovf got %b want 0", ovf_m); end
      en = 1'b0; frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      do_reset();
      send_frame(8'hC3);
      send_frame(8'h5A);
      checks++; if (data_m !== 8'hC3 || valid_m !== 1'b1) begin errors++; $display("FAIL bp_hold got %h valid %b want c3 1", data_m, valid_m); end
      checks++; if (ovf_m !== 1'b1) begin errors++; $display("FAIL bp_ovf got %b want 1", ovf_m); end
      en = 1'b0; frame_ready = 1'b1;
      tick();
      checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL bp_transfer got %b want 0", valid_m); end
      tick();
      checks++; if (ovf_m !== 1'b1) begin errors++; $display("FAIL bp_ovf_sticky got %b want 1", ovf_m); end
      frame_ready = 1'b0;
   endtask

   task automatic test_abort_reset();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         din = 1'b1; en = 1'b1;
         tick();
      end
      checks++; if (idx_m !== 4'd5) begin errors++; $display("FAIL abort_idx5 got %0d want 5", idx_m); end
      en = 1'b0;
      tick();
      checks++; if (idx_m !== 4'd0 || valid_m !== 1'b0) begin errors++; $display("FAIL abort got idx %0d valid %b want 0 0", idx_m, valid_m); end
      send_frame(8'h69);
      checks++; if (valid_m !== 1'b1 || data_m !== 8'h69) begin errors++; $display("FAIL abort_fresh got %h valid %b want 69 1", data_m, valid_m); end
      send_frame(8'h11);
      checks++; if (ovf_m !== 1'b1 || data_m !== 8'h69) begin errors++; $display("FAIL abort_ovf got ovf %b data %h want 1 69", ovf_m, data_m); end
      for (int i = 0; i < 3; i++) begin
         din = 1'b1; en = 1'b1;
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0; en = 1'b0;
      checks++; if (data_m !== 8'h00 || valid_m !== 1'b0 || ovf_m !== 1'b0 || idx_m !== 4'd0) begin
         errors++; $display("FAIL midreset got data %h valid %b ovf %b idx %0d want 00 0 0 0", data_m, valid_m, ovf_m, idx_m);
      end
   endtask

`ifdef WAVE_CAPTURE_EDGECNT_EN
   task automatic test_edge_cnt();
      do_reset();
      checks++; if (ecnt_m !== 5'd0) begin errors++; $display("FAIL ecnt_reset got %0d want 0", ecnt_m); end
      frame_ready = 1'b1;
      din = 1'b0; en = 1'b0;
      tick();
      send_frame(8'h55);
      checks++; if (ecnt_m !== 5'd4 || data_m !== 8'h55) begin errors++; $display("FAIL ecnt_alt got %0d data %h want 4 55", ecnt_m, data_m); end
      checks++; if (ecnt_l !== 5'd4) begin errors++; $display("FAIL ecnt_alt_lsb got %0d want 4", ecnt_l); end
      en = 1'b0; din = 1'b0;
      tick();
      send_frame(8'hFF);
      checks++; if (ecnt_m !== 5'd1 || valid_m !== 1'b1) begin errors++; $display("FAIL ecnt_ones got %0d valid %b want 1 1", ecnt_m, valid_m); end
      en = 1'b0;
      tick();
      frame_ready = 1'b0;
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      test_reset();
      test_basic();
      test_back_to_back();
      test_simultaneous();
      test_backpressure();
      test_abort_reset();
`ifdef WAVE_CAPTURE_EDGECNT_EN
      test_edge_cnt();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_wave_capture

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 8, meaning the number of serial bits per captured frame, legal range 2..16.
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning the first sampled bit lands in frame_data[FRAME_LEN-1] when 1 and in frame_data[0] when 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port din, input, 1 bit: the serial waveform from the upstream wave generator, sampled every clk cycle.
REQ-006 SHALL have port en, input, 1 bit: capture enable.
REQ-007 SHALL have port frame_data, output, FRAME_LEN bits: the captured frame.
REQ-008 SHALL have port frame_valid, output, 1 bit: frame_data holds an unconsumed frame.
REQ-009 SHALL have port frame_ready, input, 1 bit: the consumer accepts the frame when frame_valid and frame_ready are both 1 at a clk edge.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag, set when a completed frame was dropped.
REQ-011 SHALL have port bit_idx, output, 4 bits: the index of the next bit to be sampled within the current frame.

Function
REQ-012 SHALL implement the states IDLE and CAPTURE.
REQ-013 SHALL go from IDLE to CAPTURE on the edge where en=1; the din value at that same edge is bit 0.
REQ-014 SHALL, in CAPTURE, shift din into the shift register and increment bit_idx by 1 each cycle.
REQ-015 SHALL complete a frame on the edge that samples bit FRAME_LEN-1, then reset bit_idx to 0 and stay in CAPTURE while en=1, so back-to-back frames have no gap.
REQ-016 SHALL give a latency of one cycle: frame_valid=1 and frame_data are valid the cycle after the last bit is sampled.
REQ-017 SHALL hold frame_data stable while frame_valid=1 and frame_ready=0.
REQ-018 SHALL, when a frame completes while the holding register is full and not being consumed that edge, drop the new frame, keep the old frame, and set overflow.
REQ-019 SHALL, when a frame completes on the same edge as a consume (frame_valid and frame_ready both 1), load the new frame, keep frame_valid=1, and not set overflow.
REQ-020 SHALL, when en=0 in CAPTURE, discard the partial frame, set bit_idx to 0, and return to IDLE on that edge; a frame held in the holding register is unaffected.
REQ-021 SHALL clear overflow only by rst.

Reset
REQ-022 SHALL, on a rst=1 edge, set state to IDLE, bit_idx to 0, shift register to 0, frame_data to 0, frame_valid to 0, overflow to 0, and edge_cnt to 0.
REQ-023 SHALL give rst priority over en and over the handshake; a reset mid-frame discards all data.

Configuration
REQ-024 SHALL, when macro WAVE_CAPTURE_EDGECNT_EN is defined, add output edge_cnt (5 bits) giving the number of 0->1 transitions of din within the frame, registered alongside frame_data with the same valid/ready/drop behaviour.
REQ-025 SHALL count a transition into bit 0 only if din was 0 on the cycle before CAPTURE entry, with din history cleared by rst.
REQ-026 SHALL, when WAVE_CAPTURE_EDGECNT_EN is undefined, have no edge_cnt port and no edge-count logic.

Structure
REQ-027 SHALL place the state enum (IDLE, CAPTURE) and FRAME_LEN_MAX=16 in the shared package wave_pkg.
REQ-028 SHALL implement the transition detection and counting in one sub-module, wave_edge_det, instantiated only under WAVE_CAPTURE_EDGECNT_EN.

Verification
REQ-029 SHALL cover basic capture: FRAME_LEN=8, MSB_FIRST=1, en=1 held, din=1,0,1,1,0,0,1,0 -> frame_data=8'hB2 and frame_valid=1 exactly 1 cycle after the 8th bit.
REQ-030 SHALL cover the LSB-first variant: MSB_FIRST=0 with the same stream -> frame_data=8'h4D.
REQ-031 SHALL cover back-to-back frames: frame_ready=1 held, 3 frames -> 3 handshakes spaced 8 cycles apart and overflow=0.
REQ-032 SHALL cover backpressure: frame_ready=0 through 2 frame completions -> frame_data keeps the first frame and overflow=1; then frame_ready=1 -> one transfer, and overflow stays 1.
REQ-033 SHALL cover abort and reset: en dropped at bit_idx=5 -> no frame_valid and bit_idx=0; a re-enable then yields a full fresh frame; rst mid-frame -> all outputs 0 on the next cycle.
REQ-034 SHALL cover edge count with WAVE_CAPTURE_EDGECNT_EN: din=0,1,0,1,0,1,0,1 with din=0 before start -> edge_cnt=4; an all-ones frame after a 0 gives edge_cnt=1.
